ram_operand_multiplier: RTL and testbench
=========================================

// Module: ram_operand_multiplier
// PURPOSE
//  Initiator for the dual-read-port operand RAM: fetches two operands over the RAM's two
//  read ports, runs a serial unsigned shift-add multiply and writes the product back
//  through the RAM's dedicated multiplier write port (mul-enable/mul-data).
//  Sits between the control FSM (start/done) and the RAM; it is the only driver of the
//  RAM's read addresses and its multiplier write port.
// PARAMETERS
//  DATA_WIDTH  16  operand/product width; must match the RAM data width
//  ADDR_WIDTH   8  RAM address width
// PORTS
//  Clock            in   1           rising-edge clock shared with the RAM
//  Reset            in   1           asynchronous, active-high
//  iStart           in   1           request; sampled only in IDLE
//  iAddrA           in   ADDR_WIDTH  operand A address, latched on accepted start
//  iAddrB           in   ADDR_WIDTH  operand B address, latched on accepted start
//  oReadAddress0    out  ADDR_WIDTH  to RAM read port 0 (operand A)
//  oReadAddress1    out  ADDR_WIDTH  to RAM read port 1 (operand B)
//  iDataOut0        in   DATA_WIDTH  from RAM read port 0 (registered, 1-cycle latency)
//  iDataOut1        in   DATA_WIDTH  from RAM read port 1
//  oMulEnable       out  1           RAM multiplier-port write strobe (result to the RAM's fixed result word)
//  oDataInMul       out  DATA_WIDTH  product to RAM
//  oBusy            out  1           high while an operation is in flight
//  oDone            out  1           one-cycle pulse, coincident with oMulEnable
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; all outputs 0; operand, accumulator and
//    counter registers 0; any in-flight operation is discarded and no write is issued.
//  - All outputs are registered; no combinational input-to-output path.
//  - FSM: IDLE -> WAIT -> LOAD -> MUL -> WRITE -> IDLE.
//    IDLE : on edge E0 with iStart=1, latch iAddrA/iAddrB into oReadAddress0/1, oBusy<=1, go WAIT.
//    WAIT : one cycle; the RAM samples addresses at E1. Go LOAD.
//    LOAD : at E2, capture iDataOut0 -> A, iDataOut1 -> B; acc<=0, cnt<=0. Go MUL.
//    MUL  : one bit per edge, LSB first: if B[0] then acc<=acc+(A<<cnt); B<=B>>1; cnt++.
//           acc is 2*DATA_WIDTH bits wide. After DATA_WIDTH edges (E2+DATA_WIDTH), load
//           oDataInMul (see CONFIGURATION), set oMulEnable<=1, oDone<=1, go WRITE.
//    WRITE: one cycle with oMulEnable=oDone=1; the RAM writes at E3+DATA_WIDTH;
//           clear oMulEnable, oDone and oBusy at that edge. Go IDLE.
//  - Fixed latency, independent of operand values: oMulEnable is first seen high in
//    the cycle after edge E0+2+DATA_WIDTH (18 edges for DATA_WIDTH=16). It stays high
//    for exactly one cycle per operation.
//  - Arithmetic: unsigned. Without saturation the product is acc[DATA_WIDTH-1:0].
//  - iStart while oBusy=1 is ignored (not queued). iStart held high re-triggers in the
//    first IDLE cycle after WRITE (back-to-back period = DATA_WIDTH+4 cycles).
//  - iAddrA==iAddrB is legal (squares the word). Zero operands still take the full latency.
//  - oReadAddress0/1 hold their latched values until the next accepted start.
//  - oDataInMul holds its last product until the next write or reset.
// CONFIGURATION
//  MUL_SATURATE_EN defined: if acc[2*DATA_WIDTH-1:DATA_WIDTH] != 0, oDataInMul <=
//    all ones; otherwise oDataInMul <= low word. Latency is unchanged.
//  Not defined: oDataInMul <= acc[DATA_WIDTH-1:0] (wrap-around); no saturation logic.
// TESTING
//  1 RAM[1]=3, RAM[2]=5; start A=1, B=2 -> single oMulEnable pulse 18 edges after start,
//    oDataInMul=0x000F, oDone coincident, oBusy falls the following edge.
//  2 RAM[3]=0x00FF, RAM[4]=0x0101 -> 0xFFFF in both builds (max product with no overflow).
//  3 RAM[5]=0x1000, RAM[6]=0x0010 -> 0x0000 without MUL_SATURATE_EN; 0xFFFF with it.
//  4 RAM[7]=7; A=B=7 -> 0x0031. Pulse iStart with new addresses mid-MUL -> ignored:
//    exactly one write, result still 0x0031.
//  5 Assert Reset during MUL -> oBusy/oMulEnable/oDone 0 immediately, no write ever
//    issued; after release a new start with RAM[1], RAM[2] completes normally with 0x000F.
//  6 iStart held high for 3 operations -> oMulEnable pulses every 20 cycles;
//    RAM operand 0 -> product 0x0000 with the same latency.

Source files
------------

// File: rtl/ram_operand_multiplier.sv
// ram_operand_multiplier
//   Fetches two operands over the operand RAM's two read ports, multiplies
//   them with a serial unsigned shift-add (one multiplier bit per clock, LSB
//   first), then writes the product through the RAM's multiplier write port.
//   Latency is fixed: the write strobe is high in the cycle after edge
//   E0+2+DATA_WIDTH, where E0 is the edge that accepts the start.
//
// Ports
//   Clock, Reset                 rising-edge clock, async active-high reset
//   iStart                       request, sampled only while idle
//   iAddrA, iAddrB               operand addresses, latched on accepted start
//   oReadAddress0/1              RAM read addresses (operand A / B)
//   iDataOut0/1                  RAM read data (registered, 1-cycle latency)
//   oMulEnable, oDataInMul       RAM multiplier write strobe and product
//   oBusy                        operation in flight
//   oDone                        one-cycle pulse, coincident with oMulEnable
//
// Configuration
//   MUL_SATURATE_EN  when defined, a product that overflows DATA_WIDTH bits
//                    is written as all ones; otherwise the low word is
//                    written (wrap-around).
module ram_operand_multiplier #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iStart,
  input  logic [ADDR_WIDTH-1:0] iAddrA,
  input  logic [ADDR_WIDTH-1:0] iAddrB,
  output logic [ADDR_WIDTH-1:0] oReadAddress0,
  output logic [ADDR_WIDTH-1:0] oReadAddress1,
  input  logic [DATA_WIDTH-1:0] iDataOut0,
  input  logic [DATA_WIDTH-1:0] iDataOut1,
  output logic                  oMulEnable,
  output logic [DATA_WIDTH-1:0] oDataInMul,
  output logic                  oBusy,
  output logic                  oDone
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int AW = 2 * DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_LOAD, S_MUL, S_WRITE
  } state_t;

  state_t                state, state_d;
  logic [DATA_WIDTH-1:0] a, a_d, b, b_d;
  logic [AW-1:0]         acc, acc_d, acc_sum;
  logic [CW-1:0]         cnt, cnt_d;
  logic [ADDR_WIDTH-1:0] ra0_d, ra1_d;
  logic [DATA_WIDTH-1:0] prod_d, result;
  logic                  en_d, done_d, busy_d;
  logic                  last;

  // Partial product for the current multiplier bit; the last MUL edge both
  // folds in the final bit and loads the product, so the result is taken
  // from this sum rather than from acc.
  assign acc_sum = acc + (b[0] ? ({{DATA_WIDTH{1'b0}}, a} << cnt) : '0);
  assign last    = (cnt == CW'(DATA_WIDTH - 1));

`ifdef MUL_SATURATE_EN
  assign result = (|acc_sum[AW-1:DATA_WIDTH]) ? '1 : acc_sum[DATA_WIDTH-1:0];
`else
  assign result = acc_sum[DATA_WIDTH-1:0];
`endif

  // state register + all registered outputs / datapath
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state         <= S_IDLE;
      a             <= '0;
      b             <= '0;
      acc           <= '0;
      cnt           <= '0;
      oReadAddress0 <= '0;
      oReadAddress1 <= '0;
      oDataInMul    <= '0;
      oMulEnable    <= 1'b0;
      oDone         <= 1'b0;
      oBusy         <= 1'b0;
    end else begin
      state         <= state_d;
      a             <= a_d;
      b             <= b_d;
      acc           <= acc_d;
      cnt           <= cnt_d;
      oReadAddress0 <= ra0_d;
      oReadAddress1 <= ra1_d;
      oDataInMul    <= prod_d;
      oMulEnable    <= en_d;
      oDone         <= done_d;
      oBusy         <= busy_d;
    end
  end

  // next state
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (iStart) state_d = S_WAIT;
      S_WAIT:  state_d = S_LOAD;
      S_LOAD:  state_d = S_MUL;
      S_MUL:   if (last) state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // next values of outputs and datapath registers
  always_comb begin
    a_d    = a;
    b_d    = b;
    acc_d  = acc;
    cnt_d  = cnt;
    ra0_d  = oReadAddress0;
    ra1_d  = oReadAddress1;
    prod_d = oDataInMul;
    en_d   = oMulEnable;
    done_d = oDone;
    busy_d = oBusy;
    case (state)
      S_IDLE: if (iStart) begin
        ra0_d  = iAddrA;
        ra1_d  = iAddrB;
        busy_d = 1'b1;
      end
      S_LOAD: begin
        a_d   = iDataOut0;
        b_d   = iDataOut1;
        acc_d = '0;
        cnt_d = '0;
      end
      S_MUL: begin
        acc_d = acc_sum;
        b_d   = b >> 1;
        cnt_d = cnt + 1'b1;
        if (last) begin
          prod_d = result;
          en_d   = 1'b1;
          done_d = 1'b1;
        end
      end
      S_WRITE: begin
        en_d   = 1'b0;
        done_d = 1'b0;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_operand_multiplier.sv
module tb_ram_operand_multiplier;
  localparam int DW  = 16;
  localparam int AWD = 8;
  localparam int LAT = DW + 2;

  logic           Clock = 1'b0;
  logic           Reset = 1'b1;
  logic           iStart = 1'b0;
  logic [AWD-1:0] iAddrA = '0, iAddrB = '0;
  logic [AWD-1:0] oReadAddress0, oReadAddress1;
  logic [DW-1:0]  iDataOut0, iDataOut1;
  logic           oMulEnable, oBusy, oDone;
  logic [DW-1:0]  oDataInMul;

  ram_operand_multiplier #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWD)) dut (
    .Clock(Clock), .Reset(Reset), .iStart(iStart),
    .iAddrA(iAddrA), .iAddrB(iAddrB),
    .oReadAddress0(oReadAddress0), .oReadAddress1(oReadAddress1),
    .iDataOut0(iDataOut0), .iDataOut1(iDataOut1),
    .oMulEnable(oMulEnable), .oDataInMul(oDataInMul),
    .oBusy(oBusy), .oDone(oDone)
  );

  always #5 Clock = ~Clock;

  // operand RAM: registered reads, product lands in a fixed result word
  logic [DW-1:0] mem [256];
  logic [DW-1:0] res_word = '0;
  int            cyc = 0;
  int            nwr = 0;

  always @(posedge Clock) begin
    iDataOut0 <= mem[oReadAddress0];
    iDataOut1 <= mem[oReadAddress1];
    if (oMulEnable) begin
      res_word <= oDataInMul;
      nwr      <= nwr + 1;
    end
    cyc <= cyc + 1;
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] model(input logic [DW-1:0] x, input logic [DW-1:0] y);
    longint unsigned p;
    p = longint'(x) * longint'(y);
`ifdef MUL_SATURATE_EN
    if (p > 64'hFFFF) return '1;
`endif
    return p[DW-1:0];
  endfunction

  // drive a one-cycle start pulse; returns at the negedge after the accept edge
  task automatic start_op(input logic [AWD-1:0] ra, input logic [AWD-1:0] rb, output int t0);
    iAddrA = ra; iAddrB = rb; iStart = 1'b1; t0 = cyc;
    @(negedge Clock);
    iStart = 1'b0;
    chk("busy_rise", oBusy, 1);
    chk("raddr0", oReadAddress0, ra);
    chk("raddr1", oReadAddress1, rb);
  endtask

  // wait (bounded) for the write strobe, check latency/product/handshake
  task automatic wait_write(input string tag, input int t0, input logic [DW-1:0] exp, output int t_en);
    int n = 0;
    while (!oMulEnable && n < 60) begin @(negedge Clock); n++; end
    t_en = cyc;
    if (!oMulEnable) begin
      chk({tag, "_timeout"}, oMulEnable, 1);
      return;
    end
    chk({tag, "_lat"}, cyc - t0 - 1, LAT);
    chk({tag, "_data"}, oDataInMul, exp);
    chk({tag, "_done"}, oDone, 1);
    chk({tag, "_busy"}, oBusy, 1);
    @(negedge Clock);
    chk({tag, "_en_fall"}, oMulEnable, 0);
    chk({tag, "_busy_fall"}, oBusy, 0);
    chk({tag, "_ram"}, res_word, exp);
  endtask

  initial begin
    int t0, te, tp, w0;
    logic [DW-1:0] va, vb;
    logic [AWD-1:0] xa, xb;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[1] = 16'd3;      mem[2] = 16'd5;
    mem[3] = 16'h00FF;   mem[4] = 16'h0101;
    mem[5] = 16'h1000;   mem[6] = 16'h0010;
    mem[7] = 16'd7;      mem[8] = 16'h0000;

    repeat (2) @(negedge Clock);
    chk("rst_en", oMulEnable, 0);
    chk("rst_done", oDone, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_data", oDataInMul, 0);
    chk("rst_ra0", oReadAddress0, 0);
    Reset = 1'b0;
    @(negedge Clock);

    // basic products
    start_op(8'd1, 8'd2, t0); wait_write("t1", t0, 16'h000F, te);
    start_op(8'd3, 8'd4, t0); wait_write("t2", t0, model(16'h00FF, 16'h0101), te);
    chk("t2_ffff", oDataInMul, 16'hFFFF);
    start_op(8'd5, 8'd6, t0); wait_write("t3", t0, model(16'h1000, 16'h0010), te);

    // square with an ignored start mid-operation
    w0 = nwr;
    start_op(8'd7, 8'd7, t0);
    repeat (6) @(negedge Clock);
    iAddrA = 8'd1; iAddrB = 8'd2; iStart = 1'b1;
    @(negedge Clock);
    iStart = 1'b0;
    wait_write("t4", t0, 16'h0031, te);
    repeat (25) @(negedge Clock);
    chk("t4_one_write", nwr - w0, 1);
    chk("t4_idle", oBusy, 0);
    chk("t4_hold_data", oDataInMul, 16'h0031);

    // reset in the middle of MUL
    w0 = nwr;
    start_op(8'd1, 8'd2, t0);
    repeat (8) @(negedge Clock);
    Reset = 1'b1;
    #1;
    chk("t5_busy", oBusy, 0);
    chk("t5_en", oMulEnable, 0);
    chk("t5_done", oDone, 0);
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    repeat (25) @(negedge Clock);
    chk("t5_no_write", nwr - w0, 0);
    start_op(8'd1, 8'd2, t0); wait_write("t5b", t0, 16'h000F, te);

    // iStart held high: back-to-back operations, incl. a zero operand
    iAddrA = 8'd1; iAddrB = 8'd2; iStart = 1'b1; t0 = cyc;
    wait_write("t6a", t0, 16'h000F, tp);
    iAddrA = 8'd8; iAddrB = 8'd2; t0 = cyc;
    wait_write("t6b", t0, 16'h0000, te);
    chk("t6b_period", te - tp, DW + 4);
    tp = te;
    iAddrA = 8'd3; iAddrB = 8'd4; t0 = cyc;
    wait_write("t6c", t0, model(16'h00FF, 16'h0101), te);
    chk("t6c_period", te - tp, DW + 4);
    iStart = 1'b0;
    repeat (3) @(negedge Clock);
    chk("t6_stop", oBusy, 0);

    // randomized operands against the reference model
    for (int i = 0; i < 10; i++) begin
      xa = 8'($urandom_range(16, 250));
      xb = (i % 4 == 0) ? xa : 8'($urandom_range(16, 250));
      va = 16'($urandom);
      vb = 16'($urandom);
      if (i % 2 == 0) begin va = va & 16'h00FF; vb = vb & 16'h00FF; end
      mem[xa] = va;
      if (xb != xa) mem[xb] = vb;
      else vb = va;
      start_op(xa, xb, t0);
      wait_write($sformatf("rnd%0d", i), t0, model(va, vb), te);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
